// File: rtl/unary_stream_decoder.sv
// rtl/unary_stream_decoder.sv - unary pulse-count stream to binary converter
// A start pulse opens a WINDOW-cycle sampling window; the saturating count of 1s is then offered via valid/ready.
module unary_stream_decoder #(
  parameter int OUT_BITS = 8,
  parameter int WINDOW   = 260
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                u_in,
  input  logic                out_ready,
  output logic                busy,
  output logic                out_valid,
  output logic [OUT_BITS-1:0] out_bin,
  output logic                overflow
);

  localparam int WIN_W = $clog2(WINDOW + 1);
  localparam logic [OUT_BITS-1:0] CNT_MAX  = '1;
  localparam logic [WIN_W-1:0]    WIN_LAST = WIN_W'(WINDOW - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNT,
    S_HOLD
  } state_t;

  state_t              state_q, state_d;
  logic [OUT_BITS-1:0] cnt_q, cnt_d;
  logic [WIN_W-1:0]    win_q, win_d;
  logic                sat_q, sat_d;
  logic [OUT_BITS-1:0] out_bin_q, out_bin_d;
  logic                overflow_q, overflow_d;
  logic [OUT_BITS-1:0] cnt_next;
  logic                sat_next;

  always_comb begin
    cnt_next = cnt_q;
    sat_next = sat_q;
    if (u_in) begin
      if (cnt_q == CNT_MAX) begin
        sat_next = 1'b1;
      end else begin
        cnt_next = cnt_q + OUT_BITS'(1);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    win_d      = win_q;
    sat_d      = sat_q;
    out_bin_d  = out_bin_q;
    overflow_d = overflow_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_COUNT;
          cnt_d      = '0;
          win_d      = '0;
          sat_d      = 1'b0;
          overflow_d = 1'b0;
        end
      end
      S_COUNT: begin
        cnt_d = cnt_next;
        sat_d = sat_next;
        win_d = win_q + WIN_W'(1);
        // The final sample lands in the published result on the same edge.
        if (win_q == WIN_LAST) begin
          state_d    = S_HOLD;
          out_bin_d  = cnt_next;
          overflow_d = sat_next;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          if (start) begin
            state_d    = S_COUNT;
            cnt_d      = '0;
            win_d      = '0;
            sat_d      = 1'b0;
            overflow_d = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      win_q      <= '0;
      sat_q      <= 1'b0;
      out_bin_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      win_q      <= win_d;
      sat_q      <= sat_d;
      out_bin_q  <= out_bin_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_HOLD);
  assign out_bin   = out_bin_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_unary_stream_decoder.sv
// tb/tb_unary_stream_decoder.sv - self-checking bench for unary_stream_decoder
// Expected results come from a popcount model of each driven window.
module tb_unary_stream_decoder;

  localparam int W = 260;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       u_in = 1'b0;
  logic       out_ready = 1'b0;
  logic       busy;
  logic       out_valid;
  logic [7:0] out_bin;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  int early_cnt;
  int ovf_seen;

  unary_stream_decoder #(.OUT_BITS(8), .WINDOW(W)) dut (
    .clk(clk), .reset(reset), .start(start), .u_in(u_in), .out_ready(out_ready),
    .busy(busy), .out_valid(out_valid), .out_bin(out_bin), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int popcnt(input logic [W-1:0] p);
    int s = 0;
    for (int i = 0; i < W; i++) if (p[i]) s++;
    return s;
  endfunction

  function automatic logic [7:0] exp_bin(input int ones);
    return (ones > 255) ? 8'd255 : 8'(ones);
  endfunction

  function automatic logic [W-1:0] make_pat(input int ones);
    logic [W-1:0] p = '0;
    int n = 0;
    while (n < ones) begin
      int idx = $urandom_range(W - 1, 0);
      if (!p[idx]) begin
        p[idx] = 1'b1;
        n++;
      end
    end
    return p;
  endfunction

  task automatic send_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Drives one full window; counts cycles that were not plain COUNT cycles.
  task automatic send_window(input logic [W-1:0] pat, input int start_at, input int reset_at);
    early_cnt = 0;
    ovf_seen  = 0;
    for (int i = 0; i < W; i++) begin
      if (out_valid || !busy) early_cnt++;
      if (overflow) ovf_seen++;
      u_in  = pat[i];
      start = (i == start_at);
      if (i == reset_at) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        u_in  = 1'b0;
        start = 1'b0;
        return;
      end
      tick();
    end
    u_in  = 1'b0;
    start = 1'b0;
  endtask

  task automatic accept();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks += 4;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (out_bin !== 8'd0) begin errors++; $display("FAIL reset_bin: got %0d expected 0", out_bin); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
  endtask

  task automatic test_basic();
    logic [W-1:0] pat = '0;
    for (int i = 0; i < 12; i++) pat[i] = 1'b1;
    send_start();
    send_window(pat, -1, -1);
    checks += 4;
    if (early_cnt !== 0) begin errors++; $display("FAIL basic_timing: got %0d bad window cycles expected 0", early_cnt); end
    if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1 at start+261", out_valid); end
    if (out_bin !== 8'd12) begin errors++; $display("FAIL basic_bin: got %0d expected 12", out_bin); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %b expected 0", overflow); end
    accept();
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drop: got %b expected 0", out_valid); end
    if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle: got %b expected 0", busy); end
    if (out_bin !== 8'd12) begin errors++; $display("FAIL basic_keep: got %0d expected 12", out_bin); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] pat = '0;
    for (int i = 0; i < 240; i++) pat[i] = 1'b1;
    send_start();
    send_window(pat, -1, -1);
    for (int j = 0; j < 6; j++) begin
      checks += 2;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b expected 1", j, out_valid); end
      if (out_bin !== 8'd240) begin errors++; $display("FAIL bp_bin[%0d]: got %0d expected 240", j, out_bin); end
      out_ready = (j == 5);
      tick();
    end
    out_ready = 1'b0;
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drop: got %b expected 0", out_valid); end
    if (busy !== 1'b0) begin errors++; $display("FAIL bp_idle: got %b expected 0", busy); end
  endtask

  task automatic test_saturation();
    send_start();
    send_window('1, -1, -1);
    checks += 3;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL sat_valid: got %b expected 1", out_valid); end
    if (out_bin !== 8'd255) begin errors++; $display("FAIL sat_bin: got %0d expected 255", out_bin); end
    if (overflow !== 1'b1) begin errors++; $display("FAIL sat_ovf: got %b expected 1", overflow); end
    accept();
    send_start();
    send_window('0, -1, -1);
    checks += 3;
    if (ovf_seen !== 0) begin errors++; $display("FAIL sat_ovf_clear_in_count: got %0d cycles high expected 0", ovf_seen); end
    if (out_bin !== 8'd0) begin errors++; $display("FAIL sat_zero_bin: got %0d expected 0", out_bin); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL sat_zero_ovf: got %b expected 0", overflow); end
    accept();
  endtask

  task automatic test_back_to_back();
    int ones = $urandom_range(30, 0);
    send_start();
    send_window(make_pat(ones), -1, -1);
    checks += 1;
    if (out_bin !== exp_bin(ones)) begin errors++; $display("FAIL b2b_first: got %0d expected %0d", out_bin, exp_bin(ones)); end
    start = 1'b1;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    out_ready = 1'b0;
    checks += 2;
    if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b expected 1", busy); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drop: got %b expected 0", out_valid); end
    send_window(make_pat(5), -1, -1);
    checks += 4;
    if (early_cnt !== 0) begin errors++; $display("FAIL b2b_timing: got %0d bad window cycles expected 0", early_cnt); end
    if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b expected 1", out_valid); end
    if (out_bin !== 8'd5) begin errors++; $display("FAIL b2b_bin: got %0d expected 5", out_bin); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_ovf: got %b expected 0", overflow); end
    accept();
  endtask

  task automatic test_ignored_start();
    send_start();
    send_window(make_pat(20), 100, -1);
    checks += 3;
    if (early_cnt !== 0) begin errors++; $display("FAIL ign_timing: got %0d bad window cycles expected 0", early_cnt); end
    if (out_valid !== 1'b1) begin errors++; $display("FAIL ign_valid: got %b expected 1", out_valid); end
    if (out_bin !== 8'd20) begin errors++; $display("FAIL ign_bin: got %0d expected 20", out_bin); end
    accept();
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    send_start();
    send_window('1, -1, 50);
    checks += 4;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b expected 0", out_valid); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    if (out_bin !== 8'd0) begin errors++; $display("FAIL rst_mid_bin: got %0d expected 0", out_bin); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL rst_mid_ovf: got %b expected 0", overflow); end
    u_in = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (out_valid || busy) seen++;
      tick();
    end
    u_in = 1'b0;
    checks += 1;
    if (seen !== 0) begin errors++; $display("FAIL rst_mid_no_result: got %0d active cycles expected 0", seen); end
    send_start();
    send_window(make_pat(7), -1, -1);
    checks += 2;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_fresh_valid: got %b expected 1", out_valid); end
    if (out_bin !== 8'd7) begin errors++; $display("FAIL rst_fresh_bin: got %0d expected 7", out_bin); end
    accept();
  endtask

  task automatic test_random();
    for (int k = 0; k < 5; k++) begin
      logic [W-1:0] pat;
      int pct = $urandom_range(100, 0);
      int ready_always = $urandom_range(1, 0);
      int ones;
      for (int i = 0; i < W; i++) pat[i] = ($urandom_range(99, 0) < pct);
      ones = popcnt(pat);
      out_ready = ready_always[0];
      send_start();
      send_window(pat, -1, -1);
      checks += 4;
      if (early_cnt !== 0) begin errors++; $display("FAIL rnd%0d_timing: got %0d bad window cycles expected 0", k, early_cnt); end
      if (out_valid !== 1'b1) begin errors++; $display("FAIL rnd%0d_valid: got %b expected 1", k, out_valid); end
      if (out_bin !== exp_bin(ones)) begin errors++; $display("FAIL rnd%0d_bin: got %0d expected %0d", k, out_bin, exp_bin(ones)); end
      if (overflow !== (ones > 255)) begin errors++; $display("FAIL rnd%0d_ovf: got %b expected %b", k, overflow, ones > 255); end
      if (ready_always != 0) begin
        tick();
      end else begin
        int d = $urandom_range(4, 0);
        for (int j = 0; j < d; j++) begin
          tick();
          checks += 1;
          if (out_valid !== 1'b1 || out_bin !== exp_bin(ones)) begin
            errors++;
            $display("FAIL rnd%0d_hold: got valid=%b bin=%0d expected valid=1 bin=%0d", k, out_valid, out_bin, exp_bin(ones));
          end
        end
        accept();
      end
      out_ready = 1'b0;
      checks += 1;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL rnd%0d_drop: got %b expected 0", k, out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_saturation();
    test_back_to_back();
    test_ignored_start();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/unary_stream_decoder.md
# unary_stream_decoder

Receiving end of the unary MAC datapath. It converts a serial unary (pulse-count) result stream, such as the `out` stream of `unary_shift_mac`, back into a binary value. A `start` pulse opens a fixed sampling window. The block counts the cycles in that window where `u_in` is 1, then presents the count through a valid/ready handshake. Verification uses it as the binary result collector, and the datapath uses it as the unary→binary conversion stage.

## Interface
- `OUT_BITS`, default 8: width of the binary result. 8 covers 15·15+15 = 240 for 4-bit operands.
- `WINDOW`, default 260: number of sampled cycles per conversion. Must be ≥ 1.
- `clk` in 1: single clock. All logic is rising-edge.
- `reset` in 1: synchronous, active-high. When sampled high on a rising edge, the block returns to IDLE.
- `start` in 1: request a new conversion. Honoured only as described under Operation.
- `u_in` in 1: unary stream bit. Sampled once per cycle in COUNT.
- `busy` out 1: high in COUNT and HOLD.
- `out_valid` out 1: result available. High only in HOLD.
- `out_ready` in 1: consumer accepts the result.
- `out_bin` out OUT_BITS: count of 1s sampled in the window, saturating.
- `overflow` out 1: the count saturated during this conversion. Valid together with `out_bin`.

## Operation
- **States:** IDLE, COUNT, HOLD. Encoded as a registered FSM.
- **Reset:**
  - State goes to IDLE.
  - Count register and window counter go to 0.
  - `out_bin` = 0, `overflow` = 0, `out_valid` = 0, `busy` = 0.
  - Reset has priority over every other input, in any state, including mid-COUNT and in HOLD. A partial count is discarded and no result is emitted.
- **IDLE:**
  - `start` = 1 → COUNT. Count and window counter clear to 0, and `overflow` clears.
  - `u_in` is not sampled in the `start` cycle.
- **COUNT:**
  - On each edge, if `u_in` = 1, the count increments by 1, saturating at 2^OUT_BITS−1.
  - An increment attempted while the count is already at maximum sets `overflow` (sticky for this conversion).
  - The window counter increments every COUNT cycle. Its width is clog2(WINDOW+1).
  - On the edge where the window counter equals WINDOW−1, the final sample is included and the state goes to HOLD.
  - `start` is ignored in COUNT.
- **HOLD:**
  - `out_valid` = 1. `out_bin` and `overflow` stay stable until the handshake.
  - Handshake happens when `out_valid` & `out_ready` on an edge.
    - If `start` = 1 in the same cycle: go directly to COUNT (back-to-back), with counters cleared as in IDLE.
    - Otherwise: go to IDLE.
  - `start` without `out_ready` is ignored. The result is never dropped.
- **Outputs while not in HOLD:**
  - `out_bin` keeps its last value (or 0 after reset). Consumers read it only while `out_valid` is high.
  - `overflow` reads 0 between a new start and HOLD.
- **Arithmetic:** the count is unsigned and saturating. There is no wrap-around.

## Timing
- `start` is sampled at the edge ending cycle t. COUNT occupies cycles t+1 … t+WINDOW, and `u_in` is sampled at each of those edges.
- `out_valid` rises in cycle t+WINDOW+1. Start-to-valid latency is WINDOW+1 cycles.
- The handshake takes effect at the accepting edge:
  - `out_valid` falls in the next cycle.
  - With a simultaneous `start`, the new COUNT begins in the next cycle. Zero bubble cycles between conversions.
- `out_ready` may be held high permanently. HOLD then lasts exactly 1 cycle.
- `out_valid` does not depend combinationally on `out_ready`. All outputs are registered or decoded from state.
- Reset asserted in cycle r: every output shows its reset value in cycle r+1.

## Test plan
- **Basic conversion.** Defaults. Send 12 consecutive 1s (3·2+6) starting the cycle after `start`, then 0s. Expect `out_valid` at exactly start+261, `out_bin` = 12, `overflow` = 0.
- **Maximum MAC value, with back-pressure.**
  - Send 240 ones, hold `out_ready` low for 5 cycles after valid, then raise it.
  - Expect `out_bin` = 240 stable for all 6 HOLD cycles.
  - Expect `out_valid` to drop the cycle after acceptance, then `busy` = 0.
- **Saturation.** OUT_BITS = 8, all 260 samples = 1. Expect `out_bin` = 255 and `overflow` = 1. The next conversion with 0 ones returns `out_bin` = 0, `overflow` = 0.
- **Back-to-back.**
  - Raise `start` and `out_ready` together in HOLD.
  - The second window of 5 ones yields `out_bin` = 5 at 261 cycles after the handshake edge.
  - No IDLE cycle is observed (`busy` stays 1).
- **Ignored start.** Pulse `start` mid-COUNT at sample 100, with 20 ones in total. Expect a single result 20 at the original timing and no restart.
- **Reset mid-operation.**
  - Assert `reset` for 1 cycle at sample 50 of COUNT. Expect all outputs at reset values in the next cycle and no `out_valid`.
  - Then run a fresh conversion with 7 ones. Expect `out_bin` = 7.
